// File: rtl/fetch_unit_pkg.sv
// Shared fetch front-end types: FSM encoding, buffered entry layout, trap word.
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    FETCH_RUN,
    FETCH_TRAP,
    FETCH_HALT
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        misaligned;
  } fetch_entry_t;

  localparam logic [31:0] FETCH_NOP = 32'h0000_0000;
  localparam int          ENTRY_W   = $bits(fetch_entry_t);

endpackage

// File: rtl/fetch_unit_fifo.sv
// In-order instruction buffer: power-of-two ring with flush and occupancy count.
module fetch_fifo
  import fetch_unit_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = ENTRY_W,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr, wr_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Storage needs no reset; the head is only observed while count is nonzero.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= din;
  end

  assign dout = mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Fetch front end: PC ownership, handshaked imem requests, in-order buffering, redirect squash.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
  parameter int          DEPTH      = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic        o_imem_req_valid,
  input  logic        i_imem_req_ready,
  output logic [31:0] o_imem_req_addr,
  input  logic        i_imem_rsp_valid,
  input  logic [31:0] i_imem_rsp_data,
  input  logic        i_redirect_valid,
  input  logic [31:0] i_redirect_pc,
  output logic        o_inst_valid,
  input  logic        i_inst_ready,
  output logic [31:0] o_inst,
  output logic [31:0] o_inst_pc,
  output logic        o_inst_misaligned
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int SW = CW + 1;

  fetch_state_t state, state_nxt;
  logic [31:0]  fetch_pc, pc_tag;
  logic [CW-1:0] live_cnt, drop_cnt, count;
  logic [SW-1:0] occ_sum, owed_sum;
  fetch_entry_t head, push_entry;
  logic req_fire, rsp_drop, rsp_push, trap_push, push, pop;

  assign occ_sum  = SW'(count) + SW'(live_cnt);
  assign owed_sum = SW'(live_cnt) + SW'(drop_cnt);

  assign o_imem_req_valid = !i_rst && (state == FETCH_RUN) &&
                            (occ_sum < SW'(DEPTH)) && (owed_sum < SW'(DEPTH));
  assign o_imem_req_addr  = fetch_pc;

  assign req_fire  = o_imem_req_valid && i_imem_req_ready;
  assign rsp_drop  = i_imem_rsp_valid && (drop_cnt != '0);
  assign rsp_push  = i_imem_rsp_valid && (drop_cnt == '0) && !i_redirect_valid;
  assign trap_push = (state == FETCH_TRAP) && (count == '0) && !i_redirect_valid;
  assign push      = rsp_push || trap_push;
  assign pop       = o_inst_valid && i_inst_ready && !i_redirect_valid;

  always_comb begin
    push_entry = '{inst: i_imem_rsp_data, pc: pc_tag, misaligned: 1'b0};
    if (trap_push) push_entry = '{inst: FETCH_NOP, pc: fetch_pc, misaligned: 1'b1};
  end

  always_comb begin
    state_nxt = state;
    if (i_redirect_valid)
      state_nxt = (i_redirect_pc[1:0] == 2'b00) ? FETCH_RUN : FETCH_TRAP;
    else if (trap_push)
      state_nxt = FETCH_HALT;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= FETCH_RUN;
    else       state <= state_nxt;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      fetch_pc <= RESET_ADDR;
      pc_tag   <= RESET_ADDR;
      live_cnt <= '0;
      drop_cnt <= '0;
    end else if (i_redirect_valid) begin
      fetch_pc <= i_redirect_pc;
      pc_tag   <= i_redirect_pc;
      live_cnt <= '0;
      // Everything still owed after this edge is stale; a response arriving now
      // settles one owed slot whether it came from the drop or the live pool.
      drop_cnt <= drop_cnt + live_cnt + CW'(req_fire) - CW'(i_imem_rsp_valid);
    end else begin
      if (req_fire) fetch_pc <= fetch_pc + 32'd4;
      if (rsp_push) pc_tag   <= pc_tag + 32'd4;
      live_cnt <= live_cnt + CW'(req_fire) - CW'(rsp_push);
      drop_cnt <= drop_cnt - CW'(rsp_drop);
    end
  end

  fetch_fifo #(.DEPTH(DEPTH), .WIDTH(ENTRY_W)) u_fifo (
    .clk   (i_clk),
    .rst   (i_rst),
    .push  (push),
    .din   (push_entry),
    .pop   (pop),
    .flush (i_redirect_valid),
    .dout  (head),
    .count (count)
  );

  assign o_inst_valid      = (count != '0);
  assign o_inst            = o_inst_valid ? head.inst : FETCH_NOP;
  assign o_inst_pc         = o_inst_valid ? head.pc : RESET_ADDR;
  assign o_inst_misaligned = o_inst_valid && head.misaligned;

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit against an epoch-tagged stream model of fetch/decode.
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam int          DEPTH  = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid, req_ready = 1'b0;
  logic [31:0] req_addr;
  logic        rsp_valid = 1'b0;
  logic [31:0] rsp_data = '0;
  logic        redir_valid = 1'b0;
  logic [31:0] redir_pc = '0;
  logic        inst_valid, inst_ready = 1'b0;
  logic [31:0] inst, inst_pc;
  logic        inst_mis;

  fetch_unit #(.RESET_ADDR(RST_PC), .DEPTH(DEPTH)) dut (
    .i_clk             (clk),
    .i_rst             (rst),
    .o_imem_req_valid  (req_valid),
    .i_imem_req_ready  (req_ready),
    .o_imem_req_addr   (req_addr),
    .i_imem_rsp_valid  (rsp_valid),
    .i_imem_rsp_data   (rsp_data),
    .i_redirect_valid  (redir_valid),
    .i_redirect_pc     (redir_pc),
    .o_inst_valid      (inst_valid),
    .i_inst_ready      (inst_ready),
    .o_inst            (inst),
    .o_inst_pc         (inst_pc),
    .o_inst_misaligned (inst_mis)
  );

  always #5 clk = ~clk;

  // Memory model: in-order pending requests, each tagged with the fetch epoch it belongs to.
  typedef struct {
    logic [31:0] addr;
    int          ep;
    int          due;
  } req_t;
  req_t mq[$];

  int tests = 0, fails = 0;
  int cyc = 0, lat = 1, last_due = 0, ep = 0;
  int req_pct = 100, pop_pct = 100;
  int buf_cnt = 0, pops = 0, hits = 0;
  int mode = 0;  // 0 fetching, 1 trap pending, 2 halted
  logic [31:0] exp_req = RST_PC, exp_pop = RST_PC, trap_pc = '0;
  bit exp_trap_head = 0;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    last_due = cyc; ep = 0; buf_cnt = 0; mode = 0;
    exp_req = RST_PC; exp_pop = RST_PC; exp_trap_head = 0;
  endtask

  // Called just after a negedge; asserts reset asynchronously mid-phase.
  task automatic apply_reset();
    #2;
    rst = 1'b1;
    req_ready = 0; rsp_valid = 0; redir_valid = 0; inst_ready = 0;
    #1;
    chk("rst_req_valid", req_valid, 0);
    chk("rst_inst_valid", inst_valid, 0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_inst_pc", inst_pc, RST_PC);
    chk("rst_misaligned", inst_mis, 0);
    repeat (2) @(negedge clk);
    model_reset();
    rst = 1'b0;
  endtask

  // One clock cycle: drive inputs, check outputs against the model, advance the model.
  task automatic step(input bit redir, input logic [31:0] tgt, input bit on_busy);
    int  live_cur, due;
    bit  rsp, fire, pop, rsp_cur;
    rsp_cur = 0;
    redir_valid = redir;
    redir_pc    = tgt;
    req_ready   = ($urandom_range(99) < req_pct);
    inst_ready  = ($urandom_range(99) < pop_pct);
    rsp = (mq.size() > 0) && (mq[0].due <= cyc);
    rsp_valid = rsp;
    rsp_data  = rsp ? memf(mq[0].addr) : $urandom;
    #1;
    if (on_busy && rsp && inst_valid && inst_ready) begin
      redir = 1; redir_valid = 1'b1; hits++;
    end
    live_cur = 0;
    foreach (mq[k]) if (mq[k].ep == ep) live_cur++;
    chk("req_valid", req_valid,
        (mode == 0) && (buf_cnt + live_cur < DEPTH) && (mq.size() < DEPTH));
    chk("inst_valid", inst_valid, buf_cnt > 0);
    if (req_valid) chk("req_addr", req_addr, exp_req);
    fire = req_valid && req_ready;
    pop  = inst_valid && inst_ready && !redir;
    if (pop) begin
      pops++;
      if (exp_trap_head) begin
        chk("trap_inst", inst, 32'h0);
        chk("trap_pc", inst_pc, trap_pc);
        chk("trap_flag", inst_mis, 1);
        exp_trap_head = 0;
      end else begin
        chk("pop_pc", inst_pc, exp_pop);
        chk("pop_inst", inst, memf(exp_pop));
        chk("pop_flag", inst_mis, 0);
        exp_pop += 4;
      end
    end
    if (rsp) begin
      rsp_cur = (mq[0].ep == ep) && !redir;
      void'(mq.pop_front());
    end
    if (fire) begin
      due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
      mq.push_back('{exp_req, ep, due});
      last_due = due;
      exp_req += 4;
    end
    buf_cnt = buf_cnt + int'(rsp_cur) - int'(pop);
    if (mode == 1 && !redir) begin
      buf_cnt++; mode = 2; exp_trap_head = 1;
    end
    if (redir) begin
      ep++; buf_cnt = 0; exp_trap_head = 0;
      exp_req = tgt; exp_pop = tgt; trap_pc = tgt;
      mode = (tgt[1:0] == 2'b00) ? 0 : 1;
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
    redir_valid = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(0, 32'h0, 0);
  endtask

  initial begin
    logic [31:0] t;
    @(negedge clk);
    apply_reset();

    // Sustained stream, single-cycle memory: a pop every cycle from the third on.
    lat = 1; req_pct = 100; pop_pct = 100; pops = 0;
    run(20);
    chk("throughput_pops", pops, 18);

    // Decode stall fills the buffer; then memory backpressure holds the address.
    pop_pct = 0;   run(12);
    pop_pct = 100; req_pct = 0;   run(5);
    req_pct = 100; run(10);

    // Longer latency with requests in flight, then redirect to 0x200.
    lat = 3; run(6);
    step(1, 32'h0000_0200, 0);
    run(15);

    // Redirect landing on a cycle with both a response and a decode pop.
    lat = 2; hits = 0;
    for (int i = 0; i < 40 && hits == 0; i++) step(0, 32'h0000_0400, 1);
    chk("busy_redirect_seen", hits, 1);
    run(10);

    // Misaligned target: one trap entry, then silence until a good redirect.
    step(1, 32'h0000_0202, 0);
    run(12);
    step(1, 32'h0000_0300, 0);
    run(12);

    // PC wrap across the top of the address space.
    lat = 1;
    step(1, 32'hFFFF_FFF8, 0);
    run(10);

    // Randomized traffic with random latency, readies and redirects.
    for (int i = 0; i < 400; i++) begin
      lat = $urandom_range(1, 4);
      req_pct = $urandom_range(30, 100);
      pop_pct = $urandom_range(30, 100);
      if ($urandom_range(19) == 0) begin
        t = 32'h0000_1000 + ($urandom_range(255) << 2);
        if ($urandom_range(3) == 0) t[1:0] = 2'($urandom_range(1, 3));
        step(1, t, 0);
      end else begin
        step(0, 32'h0, 0);
      end
    end

    // Reset mid-stream, then fetching restarts at the reset address.
    req_pct = 100; pop_pct = 100; lat = 2;
    run(8);
    apply_reset();
    run(15);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
